// File: rtl/ssm_pkg.sv
// rtl/ssm_pkg.sv - shared types, widths and latency constants for the SSM tile scheduler
package ssm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;

  // Fixed core pipeline depth from tile accept to y_final_valid_o
  localparam int LAT_CORE = 20;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Frame tile count: num_tok * tiles_per_tok plus one bit of headroom
  function automatic int tot_w(input int tok_w, input int tiles);
    return tok_w + $clog2(tiles) + 1;
  endfunction

endpackage

// File: rtl/ssm_out_fifo.sv
// rtl/ssm_out_fifo.sv - first-word-fall-through result FIFO with registered occupancy count
module ssm_out_fifo
  import ssm_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ssm_tile_scheduler.sv
// rtl/ssm_tile_scheduler.sv - frame sequencer gating MM2S tiles so every in-flight tile owns an output slot
module ssm_tile_scheduler
  import ssm_pkg::*;
#(
  parameter int Y_W           = 16,
  parameter int TILES_PER_TOK = 64,
  parameter int OUT_DEPTH     = 16,
  parameter int TOK_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [TOK_W-1:0] num_tok_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  output logic             s_tready_o,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  input  logic             y_valid_i,
  input  logic [Y_W-1:0]   y_data_i,
  output logic             m_tvalid_o,
  output logic [Y_W-1:0]   m_tdata_o,
  output logic             m_tlast_o,
  input  logic             m_tready_i
);

  localparam int TW = tot_w(TOK_W, TILES_PER_TOK);
  localparam int CW = cnt_w(OUT_DEPTH);
  localparam logic [TW-1:0] ONE = TW'(1);

  sched_state_e  state;
  logic [TW-1:0] total;
  logic [TW-1:0] issued;
  logic [TW-1:0] emitted;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  logic          fifo_full;
  logic          fifo_empty;
  logic          busy;
  logic          done;
  logic          err;
  logic          go;
  logic          issue;
  logic          cap_ok;
  logic          pop;
  logic          last_issue;

  // Tiles in the core plus results waiting must never exceed the FIFO, since y has no backpressure
  assign occ        = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign go         = (state == RUN) && (issued < total) && (occ < (CW+1)'(OUT_DEPTH));
  assign tile_valid_o = s_tvalid_i & go;
  assign s_tready_o   = tile_ready_i & go;
  assign issue      = s_tvalid_i & s_tready_o;
  assign cap_ok     = y_valid_i && (inflight != '0);
  assign pop        = m_tvalid_o & m_tready_i;
  assign last_issue = (issued == total - ONE);

  assign m_tvalid_o = !fifo_empty;
  assign m_tlast_o  = m_tvalid_o && (emitted == total - ONE);
  assign busy_o     = busy;
  assign done_o     = done;
  assign err_o      = err;

  ssm_out_fifo #(.W(Y_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cap_ok && !fifo_full),
    .din   (y_data_i),
    .pop   (pop),
    .dout  (m_tdata_o),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      total    <= '0;
      issued   <= '0;
      emitted  <= '0;
      inflight <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case ({issue, cap_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (issue) issued  <= issued + ONE;
      if (pop)   emitted <= emitted + ONE;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (num_tok_i == '0) begin
              err <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              err     <= 1'b0;
              total   <= TW'(num_tok_i) * TW'(TILES_PER_TOK);
              issued  <= '0;
              emitted <= '0;
            end
          end
        end
        RUN: begin
          if (issued == total) state <= DRAIN;
        end
        DRAIN: begin
          // Look ahead at the final pop so done follows the last beat by one cycle
          if ((emitted == total) || (pop && (emitted == total - ONE))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Frame length comes from num_tok only; tlast is merely cross-checked
      if (issue && (s_tlast_i != last_issue)) err <= 1'b1;
      if (y_valid_i && (inflight == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// tb/tb_ssm_tile_scheduler.sv - randomized scoreboard bench with a fixed-latency core model
module tb_ssm_tile_scheduler;
  import ssm_pkg::*;

  localparam int TPT = 4;
  localparam int OD  = 4;
  localparam int YW  = 16;
  localparam int TKW = 16;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start_i = 1'b0;
  logic [TKW-1:0] num_tok_i = '0;
  logic           busy_o, done_o, err_o;
  logic           s_tvalid_i = 1'b0, s_tlast_i = 1'b0, s_tready_o;
  logic           tile_valid_o, tile_ready_i = 1'b0;
  logic           y_valid_i = 1'b0;
  logic [YW-1:0]  y_data_i = '0;
  logic           m_tvalid_o, m_tlast_o, m_tready_i = 1'b0;
  logic [YW-1:0]  m_tdata_o;

  always #5 clk = ~clk;

  ssm_tile_scheduler #(.Y_W(YW), .TILES_PER_TOK(TPT), .OUT_DEPTH(OD), .TOK_W(TKW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .num_tok_i(num_tok_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .y_valid_i(y_valid_i), .y_data_i(y_data_i),
    .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i)
  );

  int checks = 0, failures = 0;
  int cyc = 0, frame_total = 0, issue_idx = 0, core_idx = 0, bad_idx = -1;
  int vprob = 100, rprob = 100, mprob = 100, mlow_until = 0;
  int issue_cnt = 0, pop_cnt = 0, max_out = 0, last_pop_cyc = -1, done_cyc = -1;
  bit start_req = 0, spur = 0;
  logic [TKW-1:0] tok_req = '0;
  int            due_q[$];
  logic [YW-1:0] dat_q[$];
  logic [YW:0]   exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One cycle: drive at negedge, observe the handshakes that the next posedge will take
  task automatic step();
    @(negedge clk);
    cyc++;
    start_i   = start_req;
    num_tok_i = tok_req;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      y_valid_i = 1'b1;
      y_data_i  = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end else begin
      y_valid_i = spur;
      y_data_i  = YW'($urandom);
    end
    s_tvalid_i   = (int'($urandom_range(99)) < vprob);
    tile_ready_i = (int'($urandom_range(99)) < rprob);
    m_tready_i   = (cyc >= mlow_until) && (int'($urandom_range(99)) < mprob);
    s_tlast_i    = (issue_idx == frame_total - 1) || (issue_idx == bad_idx);
    #1;
    if (tile_valid_o && tile_ready_i) begin
      due_q.push_back(cyc + LAT_CORE);
      dat_q.push_back(YW'(core_idx));
      core_idx++;
    end
    if (s_tvalid_i && s_tready_o) begin
      issue_idx++;
      issue_cnt++;
    end
    if (m_tvalid_o && m_tready_i) begin
      pop_cnt++;
      last_pop_cyc = cyc;
    end
    if (issue_cnt - pop_cnt > max_out) max_out = issue_cnt - pop_cnt;
    if (done_o) done_cyc = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("reset_outputs", {busy_o, done_o, err_o, s_tready_o, tile_valid_o, m_tvalid_o, m_tlast_o}, 0);
    start_i = 0; s_tvalid_i = 0; s_tlast_i = 0; tile_ready_i = 0; y_valid_i = 0; m_tready_i = 0;
    due_q.delete(); dat_q.delete(); exp_q.delete();
    frame_total = 0; issue_idx = 0; core_idx = 0; bad_idx = -1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic begin_frame(input int tok, input int vp, input int rp, input int mp, input int mlow, input int bad);
    vprob = vp; rprob = rp; mprob = mp; bad_idx = bad;
    frame_total = tok * TPT;
    issue_idx = 0; core_idx = 0; issue_cnt = 0; pop_cnt = 0; max_out = 0;
    done_cyc = -1; last_pop_cyc = -1;
    for (int k = 0; k < frame_total; k++) begin
      logic lastb;
      lastb = (k == frame_total - 1);
      exp_q.push_back({lastb, YW'(k)});
    end
    tok_req = TKW'(tok);
    mlow_until = cyc + 1 + mlow;
    start_req = 1;
    step();
    start_req = 0;
  endtask

  task automatic run_frame(input int tok, input int vp, input int rp, input int mp,
                           input int mlow, input int bad, input int exp_err, input string tag);
    begin_frame(tok, vp, rp, mp, mlow, bad);
    step();
    check({tag, "_busy_after_start"}, busy_o, 1);
    check({tag, "_err_cleared_by_start"}, err_o, 0);
    for (int rel = 0; rel < 4000 && done_cyc < 0; rel++) begin
      step();
      if (mlow > 0 && rel == mlow - 3) begin
        check({tag, "_stall_issued"}, issue_idx, OD);
        check({tag, "_stall_s_tready"}, s_tready_o, 0);
      end
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done_o never seen, beats=%0d required %0d", tag, pop_cnt, frame_total);
      do_reset();
      return;
    end
    check({tag, "_done_after_last_beat"}, done_cyc - last_pop_cyc, 1);
    check({tag, "_beats"}, pop_cnt, frame_total);
    check({tag, "_occupancy_le_depth"}, max_out <= OD, 1);
    step();
    check({tag, "_done_one_cycle"}, done_o, 0);
    check({tag, "_busy_dropped"}, busy_o, 0);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [YW:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: data=%0d with no beat required", m_tdata_o);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_tdata_o, e[YW-1:0]);
          check("beat_tlast", m_tlast_o, e[YW]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    do_reset();
    run_frame(1, 100, 100, 100, 0, -1, 0, "one_tok");
    run_frame(3, 100, 100, 100, 200, -1, 0, "backpressure");
    run_frame(2, 100, 100, 60, 0, -1, 0, "overlap");
    for (int i = 0; i < 5; i++)
      run_frame(int'($urandom_range(1, 3)), int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(20, 100)), 0, -1, 0, "random");

    tok_req = '0;
    frame_total = 0;
    start_req = 1;
    step();
    start_req = 0;
    step();
    check("zero_tok_err", err_o, 1);
    check("zero_tok_busy", busy_o, 0);

    run_frame(2, 100, 100, 100, 0, 1, 1, "bad_tlast");
    run_frame(1, 80, 80, 80, 0, -1, 0, "err_clear");

    begin_frame(2, 100, 100, 100, 0, -1);
    for (int k = 0; k < 300 && issue_idx < 5; k++) step();
    check("midframe_tiles_reached", issue_idx, 5);
    do_reset();
    run_frame(1, 100, 100, 100, 0, -1, 0, "after_reset");

    spur = 1;
    step();
    spur = 0;
    step();
    check("spurious_y_err", err_o, 1);
    for (int k = 0; k < 3; k++) begin
      check("spurious_y_no_output", m_tvalid_o, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
